// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-channel sync, polarity fix, tick-sampled debounce, press/release pulses
// One shared prescaler paces every channel's small stability counter.
module button_conditioner #(
   parameter int NUM_BTN      = 7,
   parameter int ACTIVE_LOW   = 1,
   parameter int TICK_DIV     = 25125,
   parameter int STABLE_TICKS = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release,
   output logic               sample_tick
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CW = $clog2(STABLE_TICKS) + 1;
   localparam logic [PW-1:0]      PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0]      CNT_LAST = CW'(STABLE_TICKS - 1);
   localparam logic [NUM_BTN-1:0] IDLE_RAW = (ACTIVE_LOW != 0) ? '1 : '0;

   logic [NUM_BTN-1:0] sync_ff1;
   logic [NUM_BTN-1:0] sync_ff2;
   logic [NUM_BTN-1:0] pressed;
   logic [PW-1:0]      pre_cnt;
   logic [PW-1:0]      pre_next;

   // Synchronisers reset to the idle pin level so reset never looks like a press.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_ff1 <= IDLE_RAW;
         sync_ff2 <= IDLE_RAW;
      end else begin
         sync_ff1 <= btn_raw;
         sync_ff2 <= sync_ff1;
      end
   end

   assign pressed = sync_ff2 ^ IDLE_RAW;

   always_comb begin
      pre_next = (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PW'(1);
   end

   // Tick is registered from the next count so it reads 0 straight out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt     <= '0;
         sample_tick <= 1'b0;
      end else begin
         pre_cnt     <= pre_next;
         sample_tick <= (pre_next == PRE_LAST);
      end
   end

   genvar g;
   generate
      for (g = 0; g < NUM_BTN; g++) begin : g_chan
         logic [CW-1:0] cnt;
         logic          level_q;
         logic          press_q;
         logic          release_q;

         // Any agreeing cycle restarts the window, so bounces never accumulate.
         always_ff @(posedge clk) begin
            if (rst) begin
               cnt       <= '0;
               level_q   <= 1'b0;
               press_q   <= 1'b0;
               release_q <= 1'b0;
            end else begin
               press_q   <= 1'b0;
               release_q <= 1'b0;
               if (pressed[g] == level_q) begin
                  cnt <= '0;
               end else if (sample_tick) begin
                  if (cnt == CNT_LAST) begin
                     cnt       <= '0;
                     level_q   <= pressed[g];
                     press_q   <= pressed[g];
                     release_q <= ~pressed[g];
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
         end

         assign btn_level[g]   = level_q;
         assign btn_press[g]   = press_q;
         assign btn_release[g] = release_q;
      end
   endgenerate

endmodule
